// File: rtl/uart_rxd.sv
// 8N1 UART receiver: synchronizes Rxd, recovers start/8 data/stop frames and
// presents each good byte with a one-cycle rx_done strobe.
module uart_rxd #(
  parameter int CLK_FREQ_HZ = 20_000_000,
  parameter int BAUD        = 256000
) (
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic       Rxd,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        rxd_sync1_q, rxd_sync2_q, rxd_prev_q;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        rx_done_q, rx_done_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_busy_q, rx_busy_d;
  logic        rx_s;
  logic        fall_s;
  logic        tick_s;

  assign rx_s   = rxd_sync2_q;
  assign fall_s = rxd_prev_q & ~rxd_sync2_q;

  // Two-stage synchronizer plus edge-detect register, idling high.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      rxd_sync1_q <= 1'b1;
      rxd_sync2_q <= 1'b1;
      rxd_prev_q  <= 1'b1;
    end else begin
      rxd_sync1_q <= Rxd;
      rxd_sync2_q <= rxd_sync1_q;
      rxd_prev_q  <= rxd_sync2_q;
    end
  end

  // Sample tick: half a bit into START, a full bit period in DATA/STOP.
  always_comb begin
    tick_s = 1'b0;
    case (state_q)
      ST_START: tick_s = (baud_cnt_q == HALF_LAST);
      ST_DATA:  tick_s = (baud_cnt_q == BAUD_LAST);
      ST_STOP:  tick_s = (baud_cnt_q == BAUD_LAST);
      default:  tick_s = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          // A start bit that is already high again at mid-bit is a glitch.
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && (bit_cnt_q == 3'd7)) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Baud counter, bit counter and shift register next-state.
  always_comb begin
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    if ((state_q == ST_IDLE) || (state_d != state_q) || tick_s) begin
      baud_cnt_d = 16'd0;
    end else begin
      baud_cnt_d = baud_cnt_q + 16'd1;
    end
    if (state_q == ST_IDLE) begin
      bit_cnt_d = 3'd0;
    end else if ((state_q == ST_DATA) && tick_s) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = {rx_s, shift_q[7:1]};
    end else begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
    end
  end

  // FSM outputs: strobes and data update on the edge that leaves STOP.
  always_comb begin
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    data_out_d  = data_out_q;
    rx_busy_d   = (state_d != ST_IDLE);
    if ((state_q == ST_STOP) && tick_s) begin
      rx_done_d   = rx_s;
      frame_err_d = ~rx_s;
      data_out_d  = rx_s ? shift_q : data_out_q;
    end else begin
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;
      data_out_d  = data_out_q;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      baud_cnt_q  <= 16'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_out_q  <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  assign data_out  = data_out_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rxd.sv
// Directed self-checking bench for uart_rxd at default baud settings
// (78 cycles/bit, rx_done 744 cycles after the start-bit fall is driven).
module tb_uart_rxd;

  localparam int BIT_CYC  = 78;
  localparam int DONE_LAT = 744;
  localparam int BUSY_LAT = 3;

  logic       SYS_CLK = 1'b0;
  logic       RST_N   = 1'b0;
  logic       Rxd     = 1'b1;
  logic [7:0] data_out;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  int tests    = 0;
  int failures = 0;

  int cyc = 0;
  int frame_cyc = 0;
  int n_done = 0;
  int n_err = 0;
  int busy_cycles = 0;
  int viol = 0;
  int last_done_cyc = 0;
  int last_err_cyc = 0;
  int busy_rise_cyc = 0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;
  logic prev_busy = 1'b0;
  logic [7:0] byte_q [$];

  int s_done, s_err, s_busy;
  logic [7:0] b0, b1, b2;

  uart_rxd dut (
    .SYS_CLK  (SYS_CLK),
    .RST_N    (RST_N),
    .Rxd      (Rxd),
    .data_out (data_out),
    .rx_done  (rx_done),
    .rx_busy  (rx_busy),
    .frame_err(frame_err)
  );

  always #25 SYS_CLK = ~SYS_CLK;

  always @(posedge SYS_CLK) cyc <= cyc + 1;

  // Observe outputs mid-cycle: count strobes, busy cycles and protocol violations.
  always @(negedge SYS_CLK) begin
    prev_done <= rx_done;
    prev_err  <= frame_err;
    prev_busy <= rx_busy;
    if (rx_done) begin
      n_done        <= n_done + 1;
      last_done_cyc <= cyc;
      byte_q.push_back(data_out);
    end
    if (frame_err) begin
      n_err        <= n_err + 1;
      last_err_cyc <= cyc;
    end
    if (rx_busy) busy_cycles <= busy_cycles + 1;
    if (rx_busy && !prev_busy) busy_rise_cyc <= cyc;
    if ((rx_done && frame_err) || (rx_done && prev_done) || (frame_err && prev_err))
      viol <= viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge SYS_CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    frame_cyc = cyc;
    Rxd = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      Rxd = b[i];
      wait_cyc(BIT_CYC);
    end
    Rxd = stop_bit;
    wait_cyc(BIT_CYC);
  endtask

  task automatic good_frame(input string tag, input logic [7:0] b);
    s_done = n_done;
    s_err  = n_err;
    s_busy = busy_cycles;
    send_frame(b, 1'b1);
    wait_cyc(10);
    check({tag, "_done_cnt"}, n_done - s_done, 1);
    check({tag, "_err_cnt"}, n_err - s_err, 0);
    check({tag, "_data"}, {24'd0, data_out}, {24'd0, b});
    check({tag, "_done_lat"}, last_done_cyc - frame_cyc, DONE_LAT);
    check({tag, "_busy_lat"}, busy_rise_cyc - frame_cyc, BUSY_LAT);
    check({tag, "_busy_len"}, busy_cycles - s_busy, DONE_LAT - BUSY_LAT);
  endtask

  initial begin
    // Reset state
    wait_cyc(5);
    #1;
    check("rst_data", {24'd0, data_out}, 32'h0);
    check("rst_done", {31'd0, rx_done}, 32'h0);
    check("rst_busy", {31'd0, rx_busy}, 32'h0);
    check("rst_ferr", {31'd0, frame_err}, 32'h0);
    @(negedge SYS_CLK);
    RST_N = 1'b1;

    // Idle line for 2000 cycles
    wait_cyc(2000);
    check("idle_done", n_done, 0);
    check("idle_err", n_err, 0);
    check("idle_busy", busy_cycles, 0);
    check("idle_data", {24'd0, data_out}, 32'h0);

    // Good frames
    good_frame("f55", 8'h55);
    good_frame("f00", 8'h00);
    good_frame("fFF", 8'hFF);
    good_frame("fA3", 8'hA3);

    // Back-to-back frames, zero idle gap
    byte_q.delete();
    s_done = n_done;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    send_frame(8'h56, 1'b1);
    wait_cyc(10);
    check("b2b_cnt", n_done - s_done, 3);
    b0 = (byte_q.size() > 0) ? byte_q[0] : 8'hxx;
    b1 = (byte_q.size() > 1) ? byte_q[1] : 8'hxx;
    b2 = (byte_q.size() > 2) ? byte_q[2] : 8'hxx;
    check("b2b_b0", {24'd0, b0}, 32'h12);
    check("b2b_b1", {24'd0, b1}, 32'h34);
    check("b2b_b2", {24'd0, b2}, 32'h56);

    // Glitch: 20 cycles low
    s_done = n_done;
    s_err  = n_err;
    s_busy = busy_cycles;
    frame_cyc = cyc;
    Rxd = 1'b0;
    wait_cyc(20);
    Rxd = 1'b1;
    wait_cyc(100);
    check("gl_busy_lat", busy_rise_cyc - frame_cyc, BUSY_LAT);
    check("gl_busy_len", busy_cycles - s_busy, 39);
    check("gl_busy_now", {31'd0, rx_busy}, 32'h0);
    check("gl_done", n_done - s_done, 0);
    check("gl_err", n_err - s_err, 0);
    check("gl_data", {24'd0, data_out}, 32'h56);

    // Framing error then break
    s_done = n_done;
    s_err  = n_err;
    send_frame(8'h3C, 1'b0);
    wait_cyc(10);
    check("fe_err", n_err - s_err, 1);
    check("fe_err_lat", last_err_cyc - frame_cyc, DONE_LAT);
    check("fe_done", n_done - s_done, 0);
    check("fe_data", {24'd0, data_out}, 32'h56);
    s_busy = busy_cycles;
    wait_cyc(2 * 10 * BIT_CYC);
    check("brk_busy", busy_cycles - s_busy, 0);
    check("brk_err", n_err - s_err, 1);
    Rxd = 1'b1;
    wait_cyc(100);
    good_frame("f81", 8'h81);

    // Reset during data bit 4 of 0xC7
    frame_cyc = cyc;
    Rxd = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      Rxd = b0[0] ^ b0[0] ^ ((8'hC7 >> i) & 8'h01) != 8'h00;
      wait_cyc(BIT_CYC);
    end
    Rxd = 1'b0;
    wait_cyc(BIT_CYC / 2);
    check("mid_busy", {31'd0, rx_busy}, 32'h1);
    RST_N = 1'b0;
    #1;
    check("mr_data", {24'd0, data_out}, 32'h0);
    check("mr_busy", {31'd0, rx_busy}, 32'h0);
    check("mr_done", {31'd0, rx_done}, 32'h0);
    check("mr_ferr", {31'd0, frame_err}, 32'h0);
    Rxd = 1'b1;
    wait_cyc(5);
    RST_N = 1'b1;
    wait_cyc(20);
    good_frame("f5A", 8'h5A);

    check("strobe_rules", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
